poci_bus_n: RTL
===============

// Module: poci_bus_n
// PURPOSE
//  Parametrised POCI interconnect: one master, NSLAVES slaves, replacing the fixed 2-slave poci_bus.
//  Table-driven address decode, slave wait states (pready), error response (pslverr) for unmapped
//  addresses and for slaves that stall past a timeout. Saturating error counter for diagnostics.
// PARAMETERS
//  NSLAVES    4                    number of slave ports, 1..16
//  SLV_BASE   {0x4000_0000+i*0x1000} per-slave base address, NSLAVES x addr_width
//  SLV_MASK   {NSLAVES{0xFFFF_F000}} per-slave compare mask; hit_i = (paddr & MASK_i) == BASE_i
//  TIMEOUT    16                   max ACCESS cycles with pready low before forced error, >=2
// PORTS
//  pclk        in   1                  bus clock
//  presetn     in   1                  synchronous reset, active low
//  m_paddr     in   addr_width         master address
//  m_pwrite    in   1                  master write strobe
//  m_psel      in   1                  master select
//  m_penable   in   1                  master enable (access phase)
//  m_pwdata    in   data_width         master write data
//  m_prdata    out  data_width         read data to master
//  m_pready    out  1                  transfer complete
//  m_pslverr   out  1                  transfer error, valid when m_pready=1
//  s_paddr     out  addr_width         broadcast address
//  s_pwrite    out  1                  broadcast write strobe
//  s_pwdata    out  data_width         broadcast write data
//  s_psel      out  NSLAVES            one-hot slave select
//  s_penable   out  1                  broadcast enable
//  s_prdata    in   NSLAVES*data_width per-slave read data
//  s_pready    in   NSLAVES            per-slave ready
//  s_pslverr   in   NSLAVES            per-slave error
//  err_cnt     out  8                  saturating count of error responses
// BEHAVIOUR
//  Reset (presetn=0 at posedge pclk): FSM->IDLE, sel_q=0, tmo_cnt=0, err_cnt=0; s_psel=0, s_penable=0,
//   m_pready=0, m_pslverr=0, m_prdata=0. Reset mid-transfer aborts it, no response delivered.
//  FSM: IDLE -> SETUP when m_psel=1 & m_penable=0.
//   SETUP (1 cycle): decode combinational from m_paddr; lowest index wins on overlap; result
//   registered into sel_q (one-hot) + unmapped flag. s_psel = hit vector & m_psel this cycle.
//   SETUP -> ACCESS next cycle (master must raise m_penable).
//   ACCESS: s_psel=sel_q, s_penable=m_penable; m_pready=s_pready[sel], m_pslverr=s_pslverr[sel],
//   m_prdata=s_prdata[sel] (combinational, zero added latency); tmo_cnt increments each cycle
//   pready is low. Unmapped: m_pready=1, m_pslverr=1, m_prdata=0 in first ACCESS cycle, no s_psel.
//   On m_pready=1: -> SETUP if m_psel stays 1 (back-to-back, m_penable low), else IDLE.
//   tmo_cnt reaching TIMEOUT-1 with pready low: -> ERR.
//   ERR (1 cycle): s_psel=0, s_penable=0 (slave released), m_pready=1, m_pslverr=1, m_prdata=0;
//   -> IDLE. Late pready from timed-out slave ignored.
//  m_penable=1 while IDLE: protocol violation; no slave selected, m_pready=1, m_pslverr=1 same cycle.
//  err_cnt +1 on every cycle m_pready&m_pslverr=1 (slave, unmapped, timeout, violation); holds at 255.
//  Reads with pslverr return data from slave unchanged (slave errors), 0 for bus-generated errors.
//  s_paddr/s_pwrite/s_pwdata are direct pass-through of master signals.
// STRUCTURE
//  pk_poci: addr_width, data_width, typedef poci_state_t {IDLE,SETUP,ACCESS,ERR},
//   default slave map constants (addr_hex, addr_ledg, addr_ledr within slave windows).
//  Sub-module poci_addr_decoder: combinational paddr -> one-hot hit + unmapped, parametrised by
//   NSLAVES/SLV_BASE/SLV_MASK. Everything sequential stays in poci_bus_n.
// TESTING (NSLAVES=4, default map, TIMEOUT=8, 24 MHz pclk)
//  Write 0x4000_2004 data 0xDEADBEEF, slave2 pready=1 -> only s_psel[2], slave2 sees data, pslverr=0.
//  Read 0x4000_1000, slave1 pready low 3 cycles, prdata 0x1234_5678 -> m_pready on 4th ACCESS cycle,
//   m_prdata=0x1234_5678, pslverr=0.
//  Read 0x5000_0000 (unmapped) -> no s_psel, m_pready=1,m_pslverr=1,m_prdata=0 in 1st ACCESS; err_cnt=1.
//  Slave3 holds pready=0 -> ERR after 8 ACCESS cycles, s_psel[3] drops, m_pslverr=1; later
//   slave3 pready ignored; err_cnt increments by 1.
//  Back-to-back write slave0 then read slave1 (m_psel held) -> SETUP follows ACCESS directly,
//   s_psel moves 0001->0010, no idle cycle.
//  presetn low during slave1 ACCESS wait -> all outputs 0 next edge, err_cnt=0; 300 forced
//   errors -> err_cnt saturates at 255.

Source files
------------

// File: rtl/poci_bus_n_pkg.sv
// rtl/poci_bus_n_pkg.sv - shared widths, FSM encoding and default slave map for the POCI interconnect
package poci_bus_n_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int MAX_SLAVES = 16;

  // Plain vector encoding keeps the state visible to legacy tools and waveform scripts
  typedef logic [1:0] poci_state_t;
  localparam poci_state_t ST_IDLE   = 2'd0;
  localparam poci_state_t ST_SETUP  = 2'd1;
  localparam poci_state_t ST_ACCESS = 2'd2;
  localparam poci_state_t ST_ERR    = 2'd3;

  // Default slave map: 4 KiB windows starting at 0x4000_0000
  localparam logic [ADDR_WIDTH-1:0] SLV_BASE0    = 32'h4000_0000;
  localparam logic [ADDR_WIDTH-1:0] SLV_STRIDE   = 32'h0000_1000;
  localparam logic [ADDR_WIDTH-1:0] DEF_SLV_MASK = 32'hFFFF_F000;

  // Peripheral registers living inside the first three default windows
  localparam logic [ADDR_WIDTH-1:0] ADDR_HEX  = 32'h4000_0000;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LEDG = 32'h4000_1000;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LEDR = 32'h4000_2000;

  function automatic logic [MAX_SLAVES*ADDR_WIDTH-1:0] f_default_base();
    logic [MAX_SLAVES*ADDR_WIDTH-1:0] map;
    map = '0;
    for (int i = 0; i < MAX_SLAVES; i++) begin
      map[i*ADDR_WIDTH +: ADDR_WIDTH] = SLV_BASE0 + ADDR_WIDTH'(i) * SLV_STRIDE;
    end
    return map;
  endfunction

  // Base table for the maximum slave count; instances take the low NSLAVES entries
  localparam logic [MAX_SLAVES*ADDR_WIDTH-1:0] DEF_SLV_MAP = f_default_base();

endpackage

// File: rtl/poci_addr_decoder.sv
// rtl/poci_addr_decoder.sv - table-driven address decode to one-hot slave hit plus unmapped flag
module poci_addr_decoder
  import poci_bus_n_pkg::*;
#(
  parameter int                            NSLAVES  = 4,
  parameter logic [NSLAVES*ADDR_WIDTH-1:0] SLV_BASE = DEF_SLV_MAP[NSLAVES*ADDR_WIDTH-1:0],
  parameter logic [NSLAVES*ADDR_WIDTH-1:0] SLV_MASK = {NSLAVES{DEF_SLV_MASK}}
) (
  input  logic [ADDR_WIDTH-1:0] i_paddr,
  output logic [NSLAVES-1:0]    o_hit,
  output logic                  o_unmapped
);

  logic w_found;

  // Scan from index 0 so overlapping windows resolve to the lowest slave
  always_comb begin
    o_hit   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (!w_found &&
          ((i_paddr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        o_hit[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
    o_unmapped = ~w_found;
  end

endmodule

// File: rtl/poci_bus_n.sv
// rtl/poci_bus_n.sv - one-master, NSLAVES-slave POCI interconnect with wait states, timeout and error count
module poci_bus_n
  import poci_bus_n_pkg::*;
#(
  parameter int                            NSLAVES  = 4,
  parameter logic [NSLAVES*ADDR_WIDTH-1:0] SLV_BASE = DEF_SLV_MAP[NSLAVES*ADDR_WIDTH-1:0],
  parameter logic [NSLAVES*ADDR_WIDTH-1:0] SLV_MASK = {NSLAVES{DEF_SLV_MASK}},
  parameter int                            TIMEOUT  = 16
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic [ADDR_WIDTH-1:0]         m_paddr,
  input  logic                          m_pwrite,
  input  logic                          m_psel,
  input  logic                          m_penable,
  input  logic [DATA_WIDTH-1:0]         m_pwdata,
  output logic [DATA_WIDTH-1:0]         m_prdata,
  output logic                          m_pready,
  output logic                          m_pslverr,
  output logic [ADDR_WIDTH-1:0]         s_paddr,
  output logic                          s_pwrite,
  output logic [DATA_WIDTH-1:0]         s_pwdata,
  output logic [NSLAVES-1:0]            s_psel,
  output logic                          s_penable,
  input  logic [NSLAVES*DATA_WIDTH-1:0] s_prdata,
  input  logic [NSLAVES-1:0]            s_pready,
  input  logic [NSLAVES-1:0]            s_pslverr,
  output logic [7:0]                    err_cnt
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  poci_state_t          r_state;
  poci_state_t          w_next;
  logic [NSLAVES-1:0]   r_sel;
  logic                 r_unmapped;
  logic [TW-1:0]        r_tmo;
  logic [7:0]           r_err_cnt;

  logic [NSLAVES-1:0]   w_hit;
  logic                 w_unmapped;
  logic                 w_idle_like;
  logic                 w_start;
  logic                 w_viol;
  logic                 w_slv_rdy;
  logic                 w_slv_err;
  logic [DATA_WIDTH-1:0] w_slv_rdata;

  poci_addr_decoder #(
    .NSLAVES  (NSLAVES),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_dec (
    .i_paddr    (m_paddr),
    .o_hit      (w_hit),
    .o_unmapped (w_unmapped)
  );

  assign s_paddr  = m_paddr;
  assign s_pwrite = m_pwrite;
  assign s_pwdata = m_pwdata;
  assign err_cnt  = r_err_cnt;

  // SETUP behaves like IDLE for a new request, so back-to-back and fresh transfers share one path
  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_SETUP);
  assign w_start     = w_idle_like && m_psel && !m_penable;
  assign w_viol      = w_idle_like && m_penable;
  assign w_slv_rdy   = |(s_pready & r_sel);
  assign w_slv_err   = |(s_pslverr & r_sel);

  // One-hot AND-OR read mux over the registered selection
  always_comb begin
    w_slv_rdata = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      w_slv_rdata = w_slv_rdata | (s_prdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_sel[i]}});
    end
  end

  // Next state plus master/slave handshake outputs
  always_comb begin
    w_next    = r_state;
    s_psel    = '0;
    s_penable = 1'b0;
    m_pready  = 1'b0;
    m_pslverr = 1'b0;
    m_prdata  = '0;
    case (r_state)
      ST_IDLE, ST_SETUP: begin
        if (w_viol) begin
          m_pready  = 1'b1;
          m_pslverr = 1'b1;
          w_next    = ST_IDLE;
        end else if (w_start) begin
          s_psel = w_hit & {NSLAVES{m_psel}};
          w_next = ST_ACCESS;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (r_unmapped) begin
          m_pready  = 1'b1;
          m_pslverr = 1'b1;
          w_next    = m_psel ? ST_SETUP : ST_IDLE;
        end else begin
          s_psel    = r_sel;
          s_penable = m_penable;
          m_pready  = w_slv_rdy;
          m_pslverr = w_slv_err;
          m_prdata  = w_slv_rdata;
          if (w_slv_rdy) begin
            w_next = m_psel ? ST_SETUP : ST_IDLE;
          end else if (r_tmo == TMO_LAST) begin
            w_next = ST_ERR;
          end
        end
      end
      default: begin
        // Slave released; any late pready from it is not routed anywhere
        m_pready  = 1'b1;
        m_pslverr = 1'b1;
        w_next    = ST_IDLE;
      end
    endcase
  end

  // State, captured decode, stall timer and saturating error counter
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_unmapped <= 1'b0;
      r_tmo      <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_sel      <= w_hit;
        r_unmapped <= w_unmapped;
        r_tmo      <= '0;
      end else if (r_state == ST_ACCESS && !r_unmapped && !w_slv_rdy) begin
        r_tmo <= r_tmo + 1'b1;
      end
      if (m_pready && m_pslverr && r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

endmodule
